decoder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 3-to-8 line decoder between eight requesters. It samples a request vector, selects one requester per grant, and drives the decoder's Enable and A/B/C select lines. It also presents the decoded one-hot grant vector F. It sits directly in front of the existing Line_Decoder and provides fairness, bounded hold time and a break-before-make gap between grants.

---
 rtl/decoder_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Round-robin arbiter that shares one 3-to-8 line decoder between eight
// requesters. One requester is granted at a time. The grant is held for at
// most MAX_HOLD cycles, and a single break-before-make RELEASE cycle always
// separates two grants.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles (legal range 1..15)
//
// Ports
//   i_clock   rising-edge clock
//   i_resetn  synchronous active-low reset
//   i_req     request vector; bit i high = requester i wants the decoder
//   o_enable  decoder enable, high only while a grant is active
//   o_a       select MSB (granted index bit 2)
//   o_b       select bit 1
//   o_c       select LSB (bit 0)
//   o_f       one-hot grant vector, zero whenever o_enable is low
//   o_busy    high in GRANT and RELEASE
// ---------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       i_clock,
  input  logic       i_resetn,
  input  logic [7:0] i_req,
  output logic       o_enable,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic [7:0] o_f,
  output logic       o_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  logic [1:0] r_state;
  logic [2:0] r_ptr;
  logic [3:0] r_cnt;
  logic [2:0] r_sel;
  logic       r_enable;
  logic [7:0] r_f;
  logic       r_busy;

  logic [1:0] w_nextState;
  logic [2:0] w_nextPtr;
  logic [3:0] w_nextCnt;
  logic [2:0] w_nextSel;
  logic [2:0] w_winner;
  logic [2:0] w_idx;

  // Round-robin search. Indices are scanned from the lowest priority
  // (r_ptr itself) to the highest (r_ptr+1), so the nearest requesting
  // index after the pointer overwrites any farther one.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int off = 8; off >= 1; off--) begin
      w_idx = r_ptr + 3'(off);
      if (i_req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  // Next-state logic. The pointer only moves when a grant ends, so the
  // index that just finished becomes the lowest priority for the next search.
  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextCnt   = r_cnt;
    w_nextSel   = r_sel;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_nextSel   = w_winner;
          w_nextCnt   = 4'd1;
          w_nextState = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!i_req[r_sel] || (r_cnt == HOLD_LIMIT)) begin
          w_nextState = ST_RELEASE;
          w_nextPtr   = r_sel;
        end else begin
          w_nextCnt = r_cnt + 4'd1;
        end
      end
      ST_RELEASE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State and output registers. The outputs are decoded from the next
  // state, so they are registered yet still line up with the state they
  // describe. There is no combinational path from i_req to any output.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 3'd7;
      r_cnt    <= 4'd0;
      r_sel    <= 3'd0;
      r_enable <= 1'b0;
      r_f      <= 8'd0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_ptr    <= w_nextPtr;
      r_cnt    <= w_nextCnt;
      r_sel    <= w_nextSel;
      r_enable <= (w_nextState == ST_GRANT);
      r_f      <= (w_nextState == ST_GRANT) ? (8'd1 << w_nextSel) : 8'd0;
      r_busy   <= (w_nextState != ST_IDLE);
    end
  end

  assign o_enable = r_enable;
  assign o_a      = r_sel[2];
  assign o_b      = r_sel[1];
  assign o_c      = r_sel[0];
  assign o_f      = r_f;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Self-checking bench for decoder_rr_arbiter. Two instances run side by side:
// dut4 with MAX_HOLD = 4 and dut1 with MAX_HOLD = 1. Every cycle, a
// behavioural model predicts the registered outputs of both instances. The
// predictions go into scoreboard queues and are compared after the edge.
// Targeted checks cover the reset values, the grant widths and the
// round-robin order.
// ---------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

  logic       clock;
  logic       resetn;
  logic [7:0] req4;
  logic [7:0] req1;

  logic       o_enable4, o_a4, o_b4, o_c4, o_busy4;
  logic [7:0] o_f4;
  logic       o_enable1, o_a1, o_b1, o_c1, o_busy1;
  logic [7:0] o_f1;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;

  // Expected {enable, a, b, c, f[7:0], busy}
  logic [12:0] expQ4[$];
  logic [12:0] expQ1[$];
  logic [2:0]  grantQ[$];

  // Model state per instance (index 0 = dut4, index 1 = dut1)
  int mState[2];
  int mPtr[2];
  int mCnt[2];
  int mSel[2];

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .i_clock (clock),
    .i_resetn(resetn),
    .i_req   (req4),
    .o_enable(o_enable4),
    .o_a     (o_a4),
    .o_b     (o_b4),
    .o_c     (o_c4),
    .o_f     (o_f4),
    .o_busy  (o_busy4)
  );

  decoder_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .i_clock (clock),
    .i_resetn(resetn),
    .i_req   (req1),
    .o_enable(o_enable1),
    .o_a     (o_a1),
    .o_b     (o_b1),
    .o_c     (o_c1),
    .o_f     (o_f1),
    .o_busy  (o_busy1)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts each check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  // Behavioural model: advance one instance by one rising edge
  task automatic modelStep(input int k, input logic [7:0] req, input logic rstn,
                           input int maxHold, output logic [12:0] expOut);
    int  idx;
    bit  found;
    logic [2:0] s;
    logic [7:0] f;
    if (!rstn) begin
      mState[k] = 0;
      mPtr[k]   = 7;
      mCnt[k]   = 0;
      mSel[k]   = 0;
    end else begin
      case (mState[k])
        0: begin
          if (req != 8'd0) begin
            found = 0;
            for (int off = 1; off <= 8; off++) begin
              idx = (mPtr[k] + off) % 8;
              if (!found && req[idx]) begin
                found   = 1;
                mSel[k] = idx;
              end
            end
            mCnt[k]   = 1;
            mState[k] = 1;
          end
        end
        1: begin
          if (!req[mSel[k]] || mCnt[k] == maxHold) begin
            mState[k] = 2;
            mPtr[k]   = mSel[k];
          end else begin
            mCnt[k] = mCnt[k] + 1;
          end
        end
        default: mState[k] = 0;
      endcase
    end
    s = 3'(mSel[k]);
    f = (mState[k] == 1) ? (8'd1 << s) : 8'd0;
    expOut = {(mState[k] == 1), s, f, (mState[k] != 0)};
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic applyStimulus(input logic rstn, input logic [7:0] r4,
                               input logic [7:0] r1);
    logic [12:0] e;
    resetn = rstn;
    req4   = r4;
    req1   = r1;
    modelStep(0, r4, rstn, 4, e);
    expQ4.push_back(e);
    modelStep(1, r1, rstn, 1, e);
    expQ1.push_back(e);
    @(posedge clock);
    #1;
    cycle++;
    checkOutput("dut4_outputs", {o_enable4, o_a4, o_b4, o_c4, o_f4, o_busy4},
                32'(expQ4.pop_front()));
    checkOutput("dut1_outputs", {o_enable1, o_a1, o_b1, o_c1, o_f1, o_busy1},
                32'(expQ1.pop_front()));
  endtask

  // Main sequence
  initial begin
    int  count;
    int  relCount;
    logic prevEn;
    logic [2:0] wrapExp[4];

    resetn = 1'b0;
    req4   = 8'd0;
    req1   = 8'd0;

    // Reset with all requests high
    applyStimulus(1'b0, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 8'hFF, 8'hFF);
    checkOutput("reset_state4", {o_enable4, o_a4, o_b4, o_c4, o_f4, o_busy4}, 32'd0);
    checkOutput("reset_state1", {o_enable1, o_a1, o_b1, o_c1, o_f1, o_busy1}, 32'd0);
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    checkOutput("first_grant4", o_f4, 32'h01);
    checkOutput("first_grant1", o_f1, 32'h01);
    applyStimulus(1'b0, 8'h00, 8'h00);

    // Single requester for two cycles
    count = 0;
    relCount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, (i < 2) ? 8'h20 : 8'h00, 8'h00);
      if (o_f4 == 8'h20 && {o_a4, o_b4, o_c4} == 3'b101) count++;
      if (o_busy4 && !o_enable4) relCount++;
    end
    checkOutput("single_width", count, 32'd2);
    checkOutput("single_release", relCount, 32'd1);

    // Continuous requester limited by the hold counter
    count = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 8'h04, 8'h00);
      if (o_f4 == 8'h04) count++;
    end
    checkOutput("maxhold_cycles", count, 32'd12);

    // Fairness with all requesters high and a single-cycle hold
    grantQ.delete();
    prevEn = 1'b0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 8'h00, 8'hFF);
      if (o_enable1 && !prevEn) grantQ.push_back({o_a1, o_b1, o_c1});
      prevEn = o_enable1;
    end
    checkOutput("rr_grant_count", grantQ.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("rr_grant_%0d", i),
                  (grantQ.size() > i) ? 32'(grantQ[i]) : 32'hFFFF, 32'(i));
    end

    // Wrap and priority after index 6 was served
    grantQ.delete();
    prevEn = 1'b0;
    applyStimulus(1'b1, 8'h00, 8'h40);
    if (o_enable1) grantQ.push_back({o_a1, o_b1, o_c1});
    prevEn = o_enable1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 8'h00, 8'b01000011);
      if (o_enable1 && !prevEn) grantQ.push_back({o_a1, o_b1, o_c1});
      prevEn = o_enable1;
    end
    wrapExp[0] = 3'd6;
    wrapExp[1] = 3'd0;
    wrapExp[2] = 3'd1;
    wrapExp[3] = 3'd6;
    checkOutput("wrap_grant_count", grantQ.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap_grant_%0d", i),
                  (grantQ.size() > i) ? 32'(grantQ[i]) : 32'hFFFF, 32'(wrapExp[i]));
    end

    // Reset while index 4 is granted
    applyStimulus(1'b1, 8'h10, 8'h00);
    checkOutput("midgrant_before", o_f4, 32'h10);
    applyStimulus(1'b0, 8'h10, 8'h00);
    checkOutput("midgrant_reset_f", o_f4, 32'h00);
    checkOutput("midgrant_reset_en", o_enable4, 32'd0);
    applyStimulus(1'b1, 8'b00010001, 8'h00);
    checkOutput("midgrant_after", o_f4, 32'h01);

    // Random traffic with occasional resets, checked against the model
    for (int i = 0; i < 100; i++) begin
      applyStimulus(($urandom_range(0, 19) != 0),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (o_f4 != 8'd0) checkOutput("onehot4", $countones(o_f4), 32'd1);
      if (o_f1 != 8'd0) checkOutput("onehot1", $countones(o_f1), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
